btn_event_decoder: RTL

Consumes the clean debounced level from the debouncer, plus the same slow m_tick strobe, and classifies button activity into single-cycle event pulses: press, release, single click, double click and long press.
Sits between input conditioning and the application control FSMs, so downstream logic never times button gestures itself.

---
 rtl/btn_pkg.sv | 27 ++
 rtl/btn_tick_counter.sv | 40 ++++
 rtl/btn_event_decoder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the button event decoder.
// Contents: state encoding (3-bit) and the default tick constants that
// match the debouncer timebase.
package btn_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] PRESSED   = 3'd1;
    localparam logic [STATE_W-1:0] LONG_HELD = 3'd2;
    localparam logic [STATE_W-1:0] WAIT2     = 3'd3;
    localparam logic [STATE_W-1:0] PRESSED2  = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        StIdle     = IDLE,
        StPressed  = PRESSED,
        StLongHeld = LONG_HELD,
        StWait2    = WAIT2,
        StPressed2 = PRESSED2
    } btn_state_e;

    localparam int unsigned DEF_LONG_TICKS   = 50;
    localparam int unsigned DEF_DCLICK_TICKS = 15;
    localparam int unsigned DEF_REPEAT_TICKS = 10;
    localparam int unsigned DEF_CNT_W        = 8;

endpackage

// File: rtl/btn_tick_counter.sv
// Tick counter for gesture timing.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clr         - clear the count (takes priority over tick)
//   tick        - increment strobe (m_tick)
//   term        - terminal value T
//   done        - tick arriving while count == T-1 (combinational)
module btn_tick_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             tick,
    input  logic [CNT_W-1:0] term,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = tick & (cnt_q == term - CNT_W'(1));

endmodule

// File: rtl/btn_event_decoder.sv
// Button gesture classifier: turns a debounced level into one-cycle pulses
// for press, release, single click, double click and long press.
// Optional auto-repeat while held long, enabled by defining BTN_AUTO_REPEAT_EN.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   level         - debounced button level (1 = pressed)
//   m_tick        - slow timebase strobe, one clk wide
//   press         - pulse on each accepted press
//   release_o     - pulse on each release ('release' is a reserved word)
//   single_click  - short press with no second press inside the window
//   double_click  - two short presses inside the window
//   long_press    - hold reached LONG_TICKS
//   repeat_o      - auto-repeat pulse, tied 0 without BTN_AUTO_REPEAT_EN
// All outputs are registered and appear the cycle after their condition.
module btn_event_decoder
    import btn_pkg::*;
#(
    parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
    parameter int unsigned DCLICK_TICKS = DEF_DCLICK_TICKS,
    parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    input  logic m_tick,
    output logic press,
    output logic release_o,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic repeat_o
);

    btn_state_e state_q, state_d;
    logic       lvl_q;
    logic       rise, fall;
    logic       done, cnt_clr, rep_clr;
    logic [CNT_W-1:0] term;

    logic press_q, press_d;
    logic rel_q, rel_d;
    logic single_q, single_d;
    logic double_q, double_d;
    logic long_q, long_d;
`ifdef BTN_AUTO_REPEAT_EN
    logic repeat_q, repeat_d;
`endif

    assign rise = level & ~lvl_q;
    assign fall = ~level & lvl_q;

    // Terminal value depends on which interval is being timed.
    always_comb begin
        unique case (state_q)
            StWait2:    term = CNT_W'(DCLICK_TICKS);
            StLongHeld: term = CNT_W'(REPEAT_TICKS);
            default:    term = CNT_W'(LONG_TICKS);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        press_d  = 1'b0;
        rel_d    = 1'b0;
        single_d = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        rep_clr  = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        repeat_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StPressed;
                    press_d = 1'b1;
                end
            end
            StPressed: begin
                // A fall on the terminal tick still counts as a short press.
                if (fall) begin
                    state_d = StWait2;
                    rel_d   = 1'b1;
                end else if (done) begin
                    state_d = StLongHeld;
                    long_d  = 1'b1;
                end
            end
            StLongHeld: begin
                if (fall) begin
                    state_d = StIdle;
                    rel_d   = 1'b1;
                end
`ifdef BTN_AUTO_REPEAT_EN
                else if (done) begin
                    repeat_d = 1'b1;
                    rep_clr  = 1'b1;
                end
`endif
            end
            StWait2: begin
                // A second press on the terminal tick still makes a double click.
                if (rise) begin
                    state_d = StPressed2;
                    press_d = 1'b1;
                end else if (done) begin
                    state_d  = StIdle;
                    single_d = 1'b1;
                end
            end
            StPressed2: begin
                if (fall) begin
                    state_d  = StIdle;
                    rel_d    = 1'b1;
                    double_d = 1'b1;
                end else if (done) begin
                    state_d = StLongHeld;
                    long_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign cnt_clr = (state_d != state_q) | rep_clr;

    btn_tick_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (cnt_clr),
        .tick (m_tick),
        .term (term),
        .done (done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            lvl_q    <= 1'b1;  // a button held through reset is not a press
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
            single_q <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            repeat_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            lvl_q    <= level;
            press_q  <= press_d;
            rel_q    <= rel_d;
            single_q <= single_d;
            double_q <= double_d;
            long_q   <= long_d;
`ifdef BTN_AUTO_REPEAT_EN
            repeat_q <= repeat_d;
`endif
        end
    end

    assign press        = press_q;
    assign release_o    = rel_q;
    assign single_click = single_q;
    assign double_click = double_q;
    assign long_press   = long_q;
`ifdef BTN_AUTO_REPEAT_EN
    assign repeat_o     = repeat_q;
`else
    assign repeat_o     = 1'b0;
`endif

endmodule
